// File: rtl/ram_fifo_ctrl_if.sv
// Stream-side bundle of the RAM-backed FIFO: write stream, read stream and occupancy.
// The FIFO takes the slave view; whoever feeds and drains it takes the master view.
interface ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [ADDR_WIDTH+1:0] count;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, count
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, count
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an external dual-port RAM: writes on port A, reads on port B, and hides
// the registered read latency behind a 2-entry output buffer so both streams run at full rate.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush_i,
  ram_fifo_ctrl_if.slave        bus,
  output logic                  ram_a_we_o,
  output logic [ADDR_WIDTH-1:0] ram_a_addr_o,
  output logic [DATA_WIDTH-1:0] ram_a_din_o,
  output logic                  ram_b_we_o,
  output logic [ADDR_WIDTH-1:0] ram_b_addr_o,
  output logic [DATA_WIDTH-1:0] ram_b_din_o,
  input  logic [DATA_WIDTH-1:0] ram_b_dout_i
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PW-1:0]         wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] ob0_q, ob0_d, ob1_q, ob1_d;
  logic [1:0]            obOcc_q, obOcc_d;

  logic [PW-1:0] ramOcc;
  logic [1:0]    obAfterPop;
  logic [2:0]    pending;
  logic          sReady, mValid, push, pop, issue;

  // A read is only issued if the buffer can still hold it once the in-flight word lands.
  always_comb begin
    ramOcc     = wrPtr_q - rdPtr_q;
    sReady     = (ramOcc != DEPTH_P) && !flush_i;
    mValid     = (obOcc_q != 2'd0);
    push       = bus.s_valid && sReady;
    pop        = mValid && bus.m_ready;
    obAfterPop = obOcc_q - {1'b0, pop};
    pending    = {1'b0, obAfterPop} + {2'b00, inflight_q};
    issue      = (ramOcc != '0) && (pending <= 3'd1) && !flush_i;
  end

  always_comb begin
    wrPtr_d    = wrPtr_q + PW'(push);
    rdPtr_d    = rdPtr_q + PW'(issue);
    inflight_d = issue;
    obOcc_d    = obAfterPop + {1'b0, inflight_q};
    ob0_d      = ob0_q;
    ob1_d      = ob1_q;
    if (!flush_i) begin
      if (pop && (obOcc_q == 2'd2)) ob0_d = ob1_q;
      // Landing RAM data goes behind whatever survives this cycle's pop.
      if (inflight_q) begin
        if (obAfterPop == 2'd0) ob0_d = ram_b_dout_i;
        else                    ob1_d = ram_b_dout_i;
      end
    end else begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      inflight_d = 1'b0;
      obOcc_d    = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      inflight_q <= 1'b0;
      obOcc_q    <= 2'd0;
      ob0_q      <= '0;
      ob1_q      <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      inflight_q <= inflight_d;
      obOcc_q    <= obOcc_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
    end
  end

  assign bus.s_ready  = sReady;
  assign bus.m_valid  = mValid;
  assign bus.m_data   = ob0_q;
  assign bus.count    = {1'b0, ramOcc}
                      + {{(ADDR_WIDTH+1){1'b0}}, inflight_q}
                      + {{ADDR_WIDTH{1'b0}}, obOcc_q};

  assign ram_a_we_o   = push;
  assign ram_a_addr_o = wrPtr_q[ADDR_WIDTH-1:0];
  assign ram_a_din_o  = bus.s_data;
  assign ram_b_we_o   = 1'b0;
  assign ram_b_addr_o = rdPtr_q[ADDR_WIDTH-1:0];
  assign ram_b_din_o  = '0;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed and randomised bench for ram_fifo_ctrl with a behavioural registered-read RAM
// and a reference queue; the FIFO's occupancy must always equal the queue length.
module tb_ram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic          ramAWe, ramBWe;
  logic [AW-1:0] ramAAddr, ramBAddr;
  logic [DW-1:0] ramADin, ramBDin, ramBDout;
  logic [DW-1:0] mem [DEPTH];

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush_i      (flush),
    .bus          (bus),
    .ram_a_we_o   (ramAWe),
    .ram_a_addr_o (ramAAddr),
    .ram_a_din_o  (ramADin),
    .ram_b_we_o   (ramBWe),
    .ram_b_addr_o (ramBAddr),
    .ram_b_din_o  (ramBDin),
    .ram_b_dout_i (ramBDout)
  );

  // Behavioural dual-port RAM with one cycle of read latency on port B.
  always @(posedge clk) begin
    if (ramAWe) mem[ramAAddr] <= ramADin;
    ramBDout <= mem[ramBAddr];
  end

  int            compareCount = 0;
  int            mismatchCount = 0;
  logic [DW-1:0] modelQ [$];
  bit            pushAcc, popAcc;
  logic [DW-1:0] popData;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, note handshakes just before the edge, then update the reference queue.
  task automatic applyStimulus(input bit sv, input logic [DW-1:0] d, input bit mr, input bit fl);
    bus.s_valid = sv;
    bus.s_data  = d;
    bus.m_ready = mr;
    flush       = fl;
    #1;
    pushAcc = sv && bus.s_ready;
    popAcc  = bus.m_valid && mr;
    popData = bus.m_data;
    @(posedge clk);
    #1;
    if (popAcc) begin
      if (modelQ.size() == 0) checkOutput("pop_when_empty", 32'(popAcc), 32'd0);
      else                    checkOutput("pop_data", 32'(popData), 32'(modelQ.pop_front()));
    end
    if (fl) modelQ.delete();
    if (pushAcc) modelQ.push_back(d);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx, outs, gaps, firstOut, popsBefore;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    flush       = 1'b0;
    rstn        = 1'b0;
    #12;
    checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(bus.m_data), 32'd0);
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd1);
    checkOutput("rst_a_we", 32'(ramAWe), 32'd0);
    checkOutput("rst_a_addr", 32'(ramAAddr), 32'd0);
    checkOutput("rst_b_addr", 32'(ramBAddr), 32'd0);
    @(negedge clk) rstn = 1'b1;

    // Single push: visible exactly three edges later.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkOutput("lat_push", 32'(pushAcc), 32'd1);
    checkOutput("lat_e0_valid", 32'(bus.m_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("lat_e1_valid", 32'(bus.m_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("lat_e2_valid", 32'(bus.m_valid), 32'd1);
    checkOutput("lat_e2_data", 32'(bus.m_data), 32'h11);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("lat_count", 32'(bus.count), 32'd0);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
    #3;
    rstn        = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    modelQ.delete();
    checkOutput("mrst_m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("mrst_count", 32'(bus.count), 32'd0);
    checkOutput("mrst_s_ready", 32'(bus.s_ready), 32'd1);
    checkOutput("mrst_a_we", 32'(ramAWe), 32'd0);
    @(negedge clk) rstn = 1'b1;

    // Fill with the consumer stalled, then drain.
    idx = 1;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(idx <= 11, 8'(idx), 1'b0, 1'b0);
      if (pushAcc) idx++;
    end
    checkOutput("fill_accepted", 32'(idx - 1), 32'd10);
    checkOutput("fill_count", 32'(bus.count), 32'd10);
    checkOutput("fill_s_ready", 32'(bus.s_ready), 32'd0);
    popsBefore = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      if (popAcc) popsBefore++;
    end
    checkOutput("drain_pops", 32'(popsBefore), 32'd10);
    checkOutput("drain_count", 32'(bus.count), 32'd0);
    checkOutput("drain_m_valid", 32'(bus.m_valid), 32'd0);

    // Continuous streaming of 64 words through a depth-8 RAM.
    idx = 0; outs = 0; gaps = 0; firstOut = -1;
    for (int c = 0; c < 100; c++) begin
      applyStimulus(idx < 64, 8'(idx), 1'b1, 1'b0);
      if (pushAcc) idx++;
      if (popAcc) begin
        if (outs == 0) firstOut = c;
        outs++;
      end else if (outs > 0 && outs < 64) begin
        gaps++;
      end
    end
    checkOutput("stream_in", 32'(idx), 32'd64);
    checkOutput("stream_out", 32'(outs), 32'd64);
    checkOutput("stream_first", 32'(firstOut), 32'd3);
    checkOutput("stream_gaps", 32'(gaps), 32'd0);

    // Flush while a RAM read is in flight.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h36, 1'b1, 1'b0);
    checkOutput("preflush_count", 32'(bus.count), 32'd6);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("flush_count", 32'(bus.count), 32'd0);
    checkOutput("flush_m_valid", 32'(bus.m_valid), 32'd0);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("postflush_e0_valid", 32'(bus.m_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("postflush_e1_valid", 32'(bus.m_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("postflush_valid", 32'(bus.m_valid), 32'd1);
    checkOutput("postflush_data", 32'(bus.m_data), 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("postflush_count", 32'(bus.count), 32'd0);

    // Full FIFO with both sides active: pop goes first, push only after the read issue.
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      applyStimulus(idx < 10, 8'(8'h40 + idx), 1'b0, 1'b0);
      if (pushAcc) idx++;
    end
    checkOutput("full_count", 32'(bus.count), 32'(DEPTH + 2));
    applyStimulus(1'b1, 8'h4A, 1'b1, 1'b0);
    checkOutput("simul_pop", 32'(popAcc), 32'd1);
    checkOutput("simul_push", 32'(pushAcc), 32'd0);
    checkOutput("simul_ready_back", 32'(bus.s_ready), 32'd1);
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 8'(8'h4A + c), 1'b1, 1'b0);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("simul_count", 32'(bus.count), 32'd0);

    // Random traffic against the reference queue.
    for (int c = 0; c < 2000; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      checkOutput("rand_count", 32'(bus.count), 32'(modelQ.size()));
      checkOutput("rand_count_max", 32'(bus.count <= 10), 32'd1);
      checkOutput("rand_b_we", 32'(ramBWe), 32'd0);
      checkOutput("rand_b_din", 32'(ramBDin), 32'd0);
    end
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("rand_drain_count", 32'(bus.count), 32'd0);
    checkOutput("rand_drain_model", 32'(modelQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Synchronous FIFO controller that drives an external `ram_dp` instance: it writes through RAM port A and reads through RAM port B. It absorbs the RAM's one-cycle registered read latency with a 2-entry output buffer, so it presents full-throughput valid/ready streams on both sides. It is used as the buffering element in crossbar channel queues, where storage lives in `ram_dp` and the control logic lives here.

## Interface
- `DATA_WIDTH`, default 8: payload width; must equal the RAM data width.
- `ADDR_WIDTH`, default 3: RAM address width; RAM depth `DEPTH` = 2^ADDR_WIDTH.
- `clk`, input, 1: clock; all logic is rising-edge.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `flush`, input, 1: synchronous clear of all FIFO state.
- `s_valid`, input, 1: write-side data valid.
- `s_ready`, output, 1: write side can accept data.
- `s_data`, input, DATA_WIDTH: write payload.
- `m_valid`, output, 1: read-side data valid.
- `m_ready`, input, 1: read-side consumer ready.
- `m_data`, output, DATA_WIDTH: read payload (head of the FIFO).
- `count`, output, ADDR_WIDTH+2: total occupancy, 0..DEPTH+2.
- `ram_a_we`, output, 1: RAM port A write enable.
- `ram_a_addr`, output, ADDR_WIDTH: RAM port A address.
- `ram_a_din`, output, DATA_WIDTH: RAM port A write data.
- `ram_b_we`, output, 1: RAM port B write enable; constant 0.
- `ram_b_addr`, output, ADDR_WIDTH: RAM port B read address.
- `ram_b_din`, output, DATA_WIDTH: RAM port B write data; constant 0.
- `ram_b_dout`, input, DATA_WIDTH: RAM port B registered read data.

## Operation
- **State registers:**
  - `wr_ptr`, `rd_ptr`: ADDR_WIDTH+1 bits each, wrap modulo 2^(ADDR_WIDTH+1).
  - `inflight`: 1 bit.
  - Output buffer `ob0` (head) and `ob1`, with `ob_occ` in 0..2.
- **RAM occupancy:** `ram_occ = wr_ptr - rd_ptr`, computed modulo 2^(ADDR_WIDTH+1), range 0..DEPTH.
- **Push:** `push = s_valid & s_ready`, where `s_ready = (ram_occ != DEPTH) & !flush`.
  - On push: `ram_a_we=1`, `ram_a_addr=wr_ptr[ADDR_WIDTH-1:0]`, `ram_a_din=s_data`, and `wr_ptr` increments.
  - `ram_a_we` is combinational and 0 when there is no push.
- **Pop:** `pop = m_valid & m_ready`, where `m_valid = (ob_occ != 0)` and `m_data = ob0`.
- **Read issue:** `issue = (ram_occ != 0) & (ob_occ + inflight - pop <= 1) & !flush`.
  - `ram_b_addr` is always `rd_ptr[ADDR_WIDTH-1:0]`.
  - On issue, `rd_ptr` increments and `inflight <= 1`; otherwise `inflight <= 0`.
- **Capture:** when `inflight=1`, `ram_b_dout` is valid in that cycle and is written into the buffer at the next edge.
  - The slot is `ob0` if the buffer is empty after this cycle's pop, otherwise `ob1`.
  - On pop with `ob_occ=2`, `ob0 <= ob1`.
  - Simultaneous pop and capture is legal; the buffer shifts, then fills.
- **Occupancy:** `count = ram_occ + inflight + ob_occ`, registered-derived and combinational.
- **No port collision:** a read never targets the slot written in the same cycle. Low pointer bits match only when `ram_occ` is 0 (no issue) or DEPTH (no push).
- **No fall-through:** `s_ready=0` when `ram_occ=DEPTH`, even if an issue happens in the same cycle.
- **Flush:** at the edge, `wr_ptr`, `rd_ptr`, `inflight` and `ob_occ` clear to 0. Any in-flight read data is discarded and RAM contents are untouched. Push and issue are suppressed during the flush cycle; pop is still honoured but has no effect.
- **Reset:** pointers, `inflight` and `ob_occ` = 0; `ob0`/`ob1` = 0.
  - Outputs during and after reset: `m_valid=0`, `m_data=0`, `count=0`, `ram_a_we=0`, `ram_a_addr=0`, `ram_b_addr=0`, `s_ready=1` (when `flush=0`).
  - Reset asserted mid-transfer drops all content immediately.

## Timing
- **Push to visible:** a push accepted at edge E0 gives `m_valid=1` in the cycle after E2 (3-cycle latency). The read is issued in cycle E0→E1, and `ram_b_dout` is valid in cycle E1→E2.
- **Throughput:** steady state with continuous `s_valid` and `m_ready` is 1 word/cycle in and out.
- **Capacity:** DEPTH words in RAM plus 2 in the buffer (plus 1 in flight, bounded by the issue rule), so maximum `count` is DEPTH+2.
- **Ready independence:** `s_ready` does not depend on `m_ready` or `s_valid` in the same cycle. `m_valid` and `m_data` are registered.
- **Data stability:** while `m_valid=1` and `m_ready=0`, `m_data` holds stable.
- **Wrap-around:** pointers wrap with no bubble; the ordering across the DEPTH boundary is preserved.

## Test plan
- **Reset values:** assert `rstn=0` mid-stream → `m_valid=0`, `count=0`, `s_ready=1`, `ram_a_we=0`. Release, push 0x11 → `m_data=0x11` with `m_valid=1` 3 cycles later.
- **Fill and drain:** hold `m_ready=0` and push 0x01..0x0B (DEPTH=8) → 10 accepted, `count=10`, `s_ready=0`. Then `m_ready=1` → out 0x01..0x0A in order, `count` reaches 0, `m_valid=0`.
- **Streaming:** continuous push of 0x00..0x3F with `m_ready=1` → after the 3-cycle fill, one word per cycle, in order, with no gaps. Pointers wrap ≥4 times.
- **Random backpressure:** random `s_valid`/`m_ready` for 2000 cycles, checked against a reference queue → no loss, duplication or reorder. `count` always matches the model and never exceeds 10. `ram_b_we` is always 0.
- **Flush mid-flight:** with `count=6` and `inflight=1`, pulse `flush` → next cycle `count=0`, `m_valid=0`. The next push 0xA5 emerges as the first output; nothing stale appears.
- **Simultaneous events:** at `count=DEPTH+2` with `m_ready=1` and `s_valid=1`, the first cycle gives pop=1 and push=0. `s_ready` returns to 1 one cycle after the first read issue, and order is preserved.
